// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with a valid/ready input handshake.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             data_valid
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

    state_t          r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]   r_cnt;
    logic            r_valid;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic            r_par;
`endif

    logic w_last_bit;
    logic w_last_cycle;
    logic w_accept;

    assign w_last_bit = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);
`ifdef BIT_SERIALIZER_PARITY_EN
    assign w_last_cycle = (r_state == ST_PARITY);
`else
    assign w_last_cycle = w_last_bit;
`endif

    // Ready in the final stream cycle lets back-to-back words flow with no gap.
    assign in_ready   = reset && ((r_state == ST_IDLE) || w_last_cycle);
    assign w_accept   = in_valid && in_ready;

    // The serial bit is the shift register MSB; it is zeroed whenever idle.
    assign data       = r_shift[WIDTH-1];
    assign data_valid = r_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state <= ST_SHIFT;
            r_shift <= in_data;
            r_cnt   <= '0;
            r_valid <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_par   <= ^in_data;
`endif
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (!w_last_bit) begin
                        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                        r_cnt   <= r_cnt + 1'b1;
                        r_valid <= 1'b1;
                    end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                        r_state <= ST_PARITY;
                        r_shift <= {r_par, {(WIDTH-1){1'b0}}};
                        r_valid <= 1'b1;
`else
                        r_state <= ST_IDLE;
                        r_shift <= '0;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
`endif
                    end
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                ST_PARITY: begin
                    r_state <= ST_IDLE;
                    r_shift <= '0;
                    r_cnt   <= '0;
                    r_valid <= 1'b0;
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_shift <= '0;
                    r_cnt   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
